// File: rtl/spi_master.sv
// Byte-wide full-duplex SPI master with a ready/ack byte interface on both sides.
// One SCK half-period per divider strobe; chip select can be held across bytes.
module spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter bit          CPOL    = 1'b0,
  parameter bit          CPHA    = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_ack,
  input  logic       tx_hold,
  input  logic       cs_release,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  // IDLE: accept a byte | SHIFT: 16 SCK edges | TAIL: one half-period of CS hold
  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       edge_q;
  logic [7:0]       shreg_q;
  logic [7:0]       rx_data_q;
  logic             hold_q;
  logic             sck_q;
  logic             mosi_q;
  logic             cs_n_q;
  logic             tx_ready_q;
  logic             rx_ready_q;
  logic             rx_overrun_q;
  logic             miso_q;
  logic             rst_meta_q;
  logic             rst_sync_n_q;

  logic strobe;
  logic leading;
  logic last_edge;
  logic sample_now;
  logic drive_now;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_meta_q   <= 1'b0;
      rst_sync_n_q <= 1'b0;
    end else begin
      rst_meta_q   <= 1'b1;
      rst_sync_n_q <= rst_meta_q;
    end
  end

  // edge_q counts completed edges, so an even count means the next edge is leading
  assign strobe     = (div_q == '0);
  assign leading    = ~edge_q[0];
  assign last_edge  = (edge_q == 4'd15);
  assign sample_now = (state_q == SHIFT) && strobe && (leading != CPHA);
  assign drive_now  = (state_q == SHIFT) && strobe && (leading == CPHA) && !last_edge;

  always_ff @(posedge sys_clk or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      state_q      <= IDLE;
      div_q        <= '0;
      edge_q       <= '0;
      shreg_q      <= '0;
      rx_data_q    <= '0;
      hold_q       <= 1'b0;
      sck_q        <= CPOL;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      tx_ready_q   <= 1'b1;
      rx_ready_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      miso_q <= spi_miso;
      if (rx_ack) begin
        rx_ready_q   <= 1'b0;
        rx_overrun_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          div_q <= '0;
          if (tx_ack) begin
            shreg_q    <= tx_data;
            hold_q     <= tx_hold;
            tx_ready_q <= 1'b0;
            cs_n_q     <= 1'b0;
            div_q      <= DIV_LOAD;
            edge_q     <= '0;
            if (!CPHA) mosi_q <= tx_data[7];
            state_q    <= SHIFT;
          end else if (cs_release) begin
            cs_n_q <= 1'b1;
          end
        end
        SHIFT: begin
          div_q <= strobe ? DIV_LOAD : div_q - DIV_W'(1);
          if (strobe) begin
            sck_q  <= ~sck_q;
            edge_q <= edge_q + 4'd1;
            if (sample_now) shreg_q <= {shreg_q[6:0], miso_q};
            if (drive_now) mosi_q <= shreg_q[7];
            if (last_edge) state_q <= TAIL;
          end
        end
        TAIL: begin
          div_q <= strobe ? DIV_LOAD : div_q - DIV_W'(1);
          if (strobe) begin
            rx_data_q  <= shreg_q;
            rx_ready_q <= 1'b1;
            if (rx_ready_q && !rx_ack) rx_overrun_q <= 1'b1;
            cs_n_q     <= ~hold_q;
            mosi_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready   = tx_ready_q;
  assign rx_data    = rx_data_q;
  assign rx_ready   = rx_ready_q;
  assign rx_overrun = rx_overrun_q;
  assign spi_sck    = sck_q;
  assign spi_mosi   = mosi_q;
  assign spi_cs_n   = cs_n_q;

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-wide, full-duplex SPI master forming the SPI end of the UART-to-SPI bridge.
- Accepts a byte on a ready/ack handshake with the same semantics as the UART transmit side: tx_data with tx_ack, tx_ready reporting idle.
- Shifts the byte out MSB-first on MOSI while capturing MISO.
- Presents the received byte with the same semantics as the UART receive side: rx_data and rx_ready, cleared by rx_ack.

Parameters:
- CLK_DIV, 4: sys_clk cycles per SCK half-period; legal range 2..1024.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to send; sampled when tx_ack & tx_ready.
- tx_ack  in  1  start request; accepted only while tx_ready=1.
- tx_hold  in  1  sampled with tx_data; 1 = keep spi_cs_n low after this byte.
- cs_release  in  1  in IDLE, deasserts a held spi_cs_n.
- tx_ready  out  1  1 = idle, can accept a byte.
- rx_data  out  8  last received byte.
- rx_ready  out  1  1 = rx_data valid and unacknowledged.
- rx_ack  in  1  clears rx_ready and rx_overrun.
- rx_overrun  out  1  sticky; a byte completed while rx_ready=1.
- spi_sck  out  1  SPI clock.
- spi_mosi  out  1  master out.
- spi_miso  in  1  master in; synchronised internally, no metastability filtering beyond one register stage is required.
- spi_cs_n  out  1  chip select, active low.

Behaviour:
- Reset (async assert, sync release) sets outputs immediately:
  - spi_cs_n=1, spi_sck=CPOL, spi_mosi=0
  - tx_ready=1, rx_ready=0, rx_data=0, rx_overrun=0
  - state=IDLE, bit counter=0, divider=0
  - Reset mid-transfer aborts; no partial byte is reported.
- Divider: counts CLK_DIV-1 down to 0. Strobe at 0, then reload. Reloaded to CLK_DIV-1 on transfer acceptance.
- IDLE:
  - tx_ready=1.
  - On tx_ack (cycle 0), at the next edge:
    - latch tx_data and tx_hold; tx_ready=0; spi_cs_n=0
    - spi_mosi=tx_data[7] if CPHA=0, else it holds its prior value
    - go to SHIFT
  - cs_release=1 with no tx_ack: spi_cs_n=1 next cycle.
  - cs_release and tx_ack in the same cycle: tx_ack wins and spi_cs_n stays 0.
- SHIFT:
  - 16 SCK edges total, one per strobe; spi_sck toggles on each strobe.
  - Odd edges are leading, even edges trailing.
  - CPHA=0: sample MISO on leading edges; drive the next bit on trailing edges, except after the 16th edge.
  - CPHA=1: drive the bit on leading edges; sample on trailing edges.
  - MSB first. The shift register combines the MOSI and MISO shifts.
  - After the 16th edge go to TAIL; spi_sck is back at CPOL.
- TAIL:
  - Wait one strobe (one half-period of CS hold). Then, in a single cycle:
    - rx_data=received byte; rx_ready=1
    - rx_overrun=1 if rx_ready was already 1 and no rx_ack in that cycle
    - spi_cs_n=1 unless the latched hold=1
    - spi_mosi=0; tx_ready=1; go to IDLE
- Latency: rx_ready and tx_ready rise 1+17*CLK_DIV cycles after the tx_ack cycle. With CLK_DIV=4 this is cycle 69.
- Held CS: a following transfer starts without CS toggling; the first SCK edge is CLK_DIV cycles after acceptance.
- rx_ack:
  - Clears rx_ready and rx_overrun next cycle.
  - If rx_ack coincides with completion: new data is loaded, rx_ready stays 1, rx_overrun=0.
- tx_ack while tx_ready=0 is ignored (no queueing).
- tx_data, tx_hold changes after acceptance have no effect.

Test Plan:
- CPOL=0, CPHA=0, CLK_DIV=4, MISO looped to MOSI, send 0xA5 hold=0:
  - cs_n falls cycle 1; 8 SCK rising edges at cycles 5,13,…,61
  - MOSI bits 1,0,1,0,0,1,0,1
  - rx_data=0xA5, rx_ready=1 and tx_ready=1 at cycle 69; cs_n=1 at cycle 69.
- Modes 1, 2, 3 with a bench SPI slave returning 0x3C for sent 0xC3:
  - rx_data=0x3C in each mode
  - sampling edges match CPHA; SCK idle level matches CPOL.
- hold=1 send 0x01 then hold=0 send 0x02:
  - cs_n stays low between bytes; rises after the second byte only.
  - Separately: hold=1 then cs_release → cs_n=1 one cycle later.
- Two transfers without rx_ack:
  - rx_data=second byte, rx_overrun=1.
  - rx_ack → both rx_ready and rx_overrun=0 next cycle.
  - Repeat with rx_ack on the completion cycle: rx_overrun stays 0.
- tx_ack pulsed mid-transfer is ignored. sys_rst_n low at edge 7:
  - cs_n=1, sck=CPOL, tx_ready=1, rx_ready=0 without waiting for a clock
  - after release, 0x5A transfers correctly.
